// File: rtl/button_conditioner_pkg.sv
// Shared sizes and defaults for the elevator push-button front end.
package button_conditioner_pkg;

   localparam int HALL_BUTTONS             = 12;
   localparam int CAR_BUTTONS              = 9;
   localparam int NUM_CARS                 = 3;
   localparam int DEFAULT_DEBOUNCE_TICK    = 4;
   localparam int DEFAULT_DEBOUNCE_SAMPLES = 3;

   // A tick of 1 still needs a 1-bit counter that simply sits at zero.
   function automatic int counter_width(input int tick);
      return (tick > 1) ? $clog2(tick) : 1;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button levels in, one-clk press pulses out, for hall and all three cars.
interface button_conditioner_if;
   import button_conditioner_pkg::*;

   logic [HALL_BUTTONS-1:0] rawFloorButton;
   logic [CAR_BUTTONS:1]    rawInternalButton1;
   logic [CAR_BUTTONS:1]    rawInternalButton2;
   logic [CAR_BUTTONS:1]    rawInternalButton3;
   logic [HALL_BUTTONS-1:0] newRealFloorButton;
   logic [CAR_BUTTONS:1]    newInternalButton1;
   logic [CAR_BUTTONS:1]    newInternalButton2;
   logic [CAR_BUTTONS:1]    newInternalButton3;

   modport master (
      output rawFloorButton, rawInternalButton1, rawInternalButton2, rawInternalButton3,
      input  newRealFloorButton, newInternalButton1, newInternalButton2, newInternalButton3
   );

   modport slave (
      input  rawFloorButton, rawInternalButton1, rawInternalButton2, rawInternalButton3,
      output newRealFloorButton, newInternalButton1, newInternalButton2, newInternalButton3
   );

endinterface

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, sampled history, debounced level and a rising-edge pulse.
module debounce_cell #(
   parameter int DEBOUNCE_SAMPLES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic sampleStrobe,
   input  logic raw,
   output logic pressPulse
);

   logic                        sync_meta_q, sync_meta_d;
   logic                        sync_q, sync_d;
   logic [DEBOUNCE_SAMPLES-1:0] hist_q, hist_d;
   logic                        stable_q, stable_d;
   logic                        pulse_q, pulse_d;

   // Stable level only moves on a unanimous history; a mixed window holds it.
   always_comb begin
      sync_meta_d = raw;
      sync_d      = sync_meta_q;
      hist_d      = hist_q;
      stable_d    = stable_q;
      if (sampleStrobe) begin
         hist_d = {hist_q[DEBOUNCE_SAMPLES-2:0], sync_q};
         if (&hist_d) begin
            stable_d = 1'b1;
         end else if (!(|hist_d)) begin
            stable_d = 1'b0;
         end
      end
      pulse_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta_q <= 1'b0;
         sync_q      <= 1'b0;
         hist_q      <= '0;
         stable_q    <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         sync_meta_q <= sync_meta_d;
         sync_q      <= sync_d;
         hist_q      <= hist_d;
         stable_q    <= stable_d;
         pulse_q     <= pulse_d;
      end
   end

   assign pressPulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces 12 hall and 3x9 car buttons into one-clk press pulses; one shared sample prescaler.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_TICK    = DEFAULT_DEBOUNCE_TICK,
   parameter int DEBOUNCE_SAMPLES = DEFAULT_DEBOUNCE_SAMPLES
) (
   input  logic                 clk,
   input  logic                 reset,
   button_conditioner_if.slave  btn
);

   localparam int               CNT_W      = counter_width(DEBOUNCE_TICK);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_TICK - 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             sample_strobe;

   always_comb begin
      sample_strobe = (count_q == LAST_COUNT);
      count_d       = sample_strobe ? '0 : count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   for (genvar i = 0; i < HALL_BUTTONS; i++) begin : g_hall
      debounce_cell #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_cell (
         .clk          (clk),
         .reset        (reset),
         .sampleStrobe (sample_strobe),
         .raw          (btn.rawFloorButton[i]),
         .pressPulse   (btn.newRealFloorButton[i])
      );
   end

   // Car vectors keep their 1-based indexing straight through.
   for (genvar j = 1; j <= CAR_BUTTONS; j++) begin : g_car
      debounce_cell #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_car1 (
         .clk          (clk),
         .reset        (reset),
         .sampleStrobe (sample_strobe),
         .raw          (btn.rawInternalButton1[j]),
         .pressPulse   (btn.newInternalButton1[j])
      );
      debounce_cell #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_car2 (
         .clk          (clk),
         .reset        (reset),
         .sampleStrobe (sample_strobe),
         .raw          (btn.rawInternalButton2[j]),
         .pressPulse   (btn.newInternalButton2[j])
      );
      debounce_cell #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_car3 (
         .clk          (clk),
         .reset        (reset),
         .sampleStrobe (sample_strobe),
         .raw          (btn.rawInternalButton3[j]),
         .pressPulse   (btn.newInternalButton3[j])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench: each press pushes the expected pulse vector and its arrival window.
module tb_button_conditioner;

   typedef struct packed {
      logic [38:0] vec;
      int          lo;
      int          hi;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          cycle = 0;
   int          vectors = 0;
   int          miscompares = 0;
   exp_t        sbQ[$];
   string       tagQ[$];
   logic [38:0] outVec;

   button_conditioner_if bif();

   button_conditioner #(.DEBOUNCE_TICK(4), .DEBOUNCE_SAMPLES(3)) dut (
      .clk   (clk),
      .reset (reset),
      .btn   (bif.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   assign outVec = {bif.newInternalButton3, bif.newInternalButton2,
                    bif.newInternalButton1, bif.newRealFloorButton};

   function automatic logic [38:0] makeVec(input logic [11:0] fl, input logic [9:1] c1,
                                           input logic [9:1] c2, input logic [9:1] c3);
      return {c3, c2, c1, fl};
   endfunction

   task automatic checkOutput(input string tag, input logic [38:0] got, input logic [38:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   task automatic applyStimulus(input logic [11:0] fl, input logic [9:1] c1,
                                input logic [9:1] c2, input logic [9:1] c3);
      bif.rawFloorButton     = fl;
      bif.rawInternalButton1 = c1;
      bif.rawInternalButton2 = c2;
      bif.rawInternalButton3 = c3;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expectPulse(input string tag, input logic [38:0] vec, input int lo, input int hi);
      exp_t e;
      e.vec = vec;
      e.lo  = lo;
      e.hi  = hi;
      sbQ.push_back(e);
      tagQ.push_back(tag);
   endtask

   // Pulses are matched in order; anything arriving with nothing pending is a stray pulse.
   always @(negedge clk) begin
      exp_t  e;
      string t;
      if (sbQ.size() > 0 && cycle > sbQ[0].hi) begin
         e = sbQ.pop_front();
         t = tagQ.pop_front();
         checkOutput({t, "_timeout"}, 39'd0, e.vec);
      end
      if (outVec != 39'd0) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected", outVec, 39'd0);
         end else begin
            e = sbQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(t, outVec, e.vec);
            checkOutput({t, "_window"}, {38'd0, (cycle >= e.lo && cycle <= e.hi)}, 39'd1);
         end
      end
   end

   initial begin
      int t0;
      applyStimulus(12'hFFF, 9'h1FF, 9'h1FF, 9'h1FF);
      reset = 1'b0;

      // Held buttons under reset must stay silent, then pulse once each on release.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("rst_out", outVec, 39'd0);
      end
      waitCycles(1);
      reset = 1'b1;
      t0 = cycle;
      expectPulse("rst_release", {39{1'b1}}, t0 + 11, t0 + 15);
      waitCycles(40);
      applyStimulus('0, '0, '0, '0);
      waitCycles(30);

      $display("[TB] clean press on hall 3");
      applyStimulus(12'h008, '0, '0, '0);
      t0 = cycle;
      expectPulse("clean_press", makeVec(12'h008, '0, '0, '0), t0 + 11, t0 + 15);
      waitCycles(40);
      applyStimulus('0, '0, '0, '0);
      waitCycles(30);

      $display("[TB] bouncing car2 button 5");
      for (int s = 0; s < 10; s++) begin
         applyStimulus('0, '0, (s % 2 == 0) ? 9'h010 : 9'h000, '0);
         waitCycles(3);
      end
      applyStimulus('0, '0, 9'h010, '0);
      t0 = cycle;
      expectPulse("bounce_settle", makeVec('0, '0, 9'h010, '0), t0 + 1, t0 + 15);
      waitCycles(40);
      applyStimulus('0, '0, '0, '0);
      waitCycles(30);

      $display("[TB] release and re-press car1 button 4");
      applyStimulus('0, 9'h008, '0, '0);
      t0 = cycle;
      expectPulse("press1", makeVec('0, 9'h008, '0, '0), t0 + 11, t0 + 15);
      waitCycles(30);
      applyStimulus('0, '0, '0, '0);
      waitCycles(30);
      applyStimulus('0, 9'h008, '0, '0);
      t0 = cycle;
      expectPulse("press2", makeVec('0, 9'h008, '0, '0), t0 + 11, t0 + 15);
      waitCycles(30);
      applyStimulus('0, '0, '0, '0);
      waitCycles(5);
      applyStimulus('0, 9'h008, '0, '0);
      waitCycles(30);
      applyStimulus('0, '0, '0, '0);
      waitCycles(30);

      $display("[TB] simultaneous press of all buttons");
      applyStimulus(12'hFFF, 9'h1FF, 9'h1FF, 9'h1FF);
      t0 = cycle;
      expectPulse("all_at_once", {39{1'b1}}, t0 + 11, t0 + 15);
      waitCycles(40);
      applyStimulus('0, '0, '0, '0);
      waitCycles(30);

      $display("[TB] reset during debounce of hall 7");
      applyStimulus(12'h080, '0, '0, '0);
      waitCycles(6);
      reset = 1'b0;
      waitCycles(2);
      reset = 1'b1;
      t0 = cycle;
      expectPulse("mid_reset", makeVec(12'h080, '0, '0, '0), t0 + 11, t0 + 15);
      waitCycles(40);
      applyStimulus('0, '0, '0, '0);
      waitCycles(30);

      checkOutput("sb_empty", 39'(sbQ.size()), 39'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
